// File: rtl/video_timing_gen_pkg.sv
// Shared geometry defaults for the raster timing generator, plus the wrap-modulo
// helper used to fold adjusted sync positions back into 0..TOTAL-1.
package video_timing_gen_pkg;

    // Arcade board mode: 240x224 visible, 6 MHz pixel clock from 48 MHz
    localparam int ARC_CE_DIV        = 8;
    localparam int ARC_CW            = 9;
    localparam int ARC_H_TOTAL       = 384;
    localparam int ARC_H_BLANK_END   = 9;
    localparam int ARC_H_BLANK_START = 249;
    localparam int ARC_H_SYNC_START  = 308;
    localparam int ARC_H_SYNC_END    = 340;
    localparam int ARC_V_TOTAL       = 264;
    localparam int ARC_V_BLANK_END   = 15;
    localparam int ARC_V_BLANK_START = 239;
    localparam int ARC_V_SYNC_START  = 258;
    localparam int ARC_V_SYNC_END    = 260;

    // One conditional correction is enough because |adjust| < total
    function automatic int wrap_mod(input int sum, input int total);
        int r;
        r = sum;
        if (sum < 0) begin
            r = sum + total;
        end else if (sum >= total) begin
            r = sum - total;
        end
        return r;
    endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: position counter with blank and sync flags. Flags compare the
// pre-increment count; the sync adjust is re-latched only at frame boundaries.
module vtg_axis
    import video_timing_gen_pkg::*;
#(
    parameter int CW          = 9,
    parameter int TOTAL       = 384,
    parameter int BLANK_END   = 9,
    parameter int BLANK_START = 249,
    parameter int SYNC_START  = 308,
    parameter int SYNC_END    = 340,
    parameter int AW          = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          step,
    input  logic          adj_load,
    input  logic [AW-1:0] adj,
    output logic [CW-1:0] count,
    output logic          wrap,
    output logic          blank,
    output logic          sync
);

    localparam logic [CW-1:0] LAST_V = CW'(TOTAL - 1);
    localparam logic [CW-1:0] BE_V   = CW'(BLANK_END);
    localparam logic [CW-1:0] BS_V   = CW'(BLANK_START);
    localparam logic [CW-1:0] SS_V   = CW'(SYNC_START);
    localparam logic [CW-1:0] SE_V   = CW'(SYNC_END);

    logic [CW-1:0]        count_q, count_d;
    logic                 blank_q, blank_d;
    logic                 sync_q, sync_d;
    logic [AW-1:0]        adj_l_q, adj_l_d;
    logic signed [CW:0]   adj_ext;
    logic signed [CW:0]   sum_on, sum_off;
    logic [CW-1:0]        sync_on, sync_off;

    // Both edges shift by the same amount, so pulse width never changes
    always_comb begin
        adj_ext  = $signed({{(CW + 1 - AW){adj_l_q[AW-1]}}, adj_l_q});
        sum_on   = $signed({1'b0, SS_V}) + adj_ext;
        sum_off  = $signed({1'b0, SE_V}) + adj_ext;
        sync_on  = CW'(wrap_mod(int'(sum_on), TOTAL));
        sync_off = CW'(wrap_mod(int'(sum_off), TOTAL));
    end

    assign wrap = step && (count_q == LAST_V);

    always_comb begin
        count_d = count_q;
        blank_d = blank_q;
        sync_d  = sync_q;
        adj_l_d = adj_l_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + CW'(1);
            if (count_q == BE_V) blank_d = 1'b0;
            if (count_q == BS_V) blank_d = 1'b1;
            if (count_q == sync_on) sync_d = 1'b0;
            if (count_q == sync_off) sync_d = 1'b1;
        end
        if (adj_load) begin
            adj_l_d = adj;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            count_q <= '0;
            blank_q <= 1'b1;
            sync_q  <= 1'b1;
            adj_l_q <= adj;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
            adj_l_q <= adj_l_d;
        end
    end

    assign count = count_q;
    assign blank = blank_q;
    assign sync  = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel enable divider, H/V axes,
// line/frame strobes and a free-running frame counter.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int CE_DIV        = ARC_CE_DIV,
    parameter int CW            = ARC_CW,
    parameter int H_TOTAL       = ARC_H_TOTAL,
    parameter int H_BLANK_END   = ARC_H_BLANK_END,
    parameter int H_BLANK_START = ARC_H_BLANK_START,
    parameter int H_SYNC_START  = ARC_H_SYNC_START,
    parameter int H_SYNC_END    = ARC_H_SYNC_END,
    parameter int V_TOTAL       = ARC_V_TOTAL,
    parameter int V_BLANK_END   = ARC_V_BLANK_END,
    parameter int V_BLANK_START = ARC_V_BLANK_START,
    parameter int V_SYNC_START  = ARC_V_SYNC_START,
    parameter int V_SYNC_END    = ARC_V_SYNC_END
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [3:0]    h_adj,
    input  logic [2:0]    v_adj,
    output logic          ce_pix,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hb,
    output logic          vb,
    output logic          hs,
    output logic          vs,
    output logic          line_start,
    output logic          frame_start,
    output logic [7:0]    frame_cnt
);

    localparam int DW = $clog2(CE_DIV);

    logic [DW-1:0] div_q, div_d;
    logic          ce_pix_q, ce_pix_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          step;
    logic          h_wrap;
    logic          v_wrap;

    // Counters advance on the same edge that raises ce_pix
    assign step = (div_q == DW'(CE_DIV - 1));

    always_comb begin
        div_d         = step ? '0 : div_q + DW'(1);
        ce_pix_d      = step;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        frame_cnt_d   = frame_cnt_q;
        if (step) begin
            line_start_d  = h_wrap;
            frame_start_d = v_wrap;
            if (v_wrap) frame_cnt_d = frame_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            div_q         <= '0;
            ce_pix_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            div_q         <= div_d;
            ce_pix_q      <= ce_pix_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    vtg_axis #(
        .CW(CW), .TOTAL(H_TOTAL),
        .BLANK_END(H_BLANK_END), .BLANK_START(H_BLANK_START),
        .SYNC_START(H_SYNC_START), .SYNC_END(H_SYNC_END), .AW(4)
    ) u_h_axis (
        .clk_sys(clk_sys), .reset(reset), .step(step), .adj_load(v_wrap),
        .adj(h_adj), .count(hcount), .wrap(h_wrap), .blank(hb), .sync(hs)
    );

    // Vertical adjust reloads together with horizontal at the frame wrap
    vtg_axis #(
        .CW(CW), .TOTAL(V_TOTAL),
        .BLANK_END(V_BLANK_END), .BLANK_START(V_BLANK_START),
        .SYNC_START(V_SYNC_START), .SYNC_END(V_SYNC_END), .AW(3)
    ) u_v_axis (
        .clk_sys(clk_sys), .reset(reset), .step(h_wrap), .adj_load(v_wrap),
        .adj(v_adj), .count(vcount), .wrap(v_wrap), .blank(vb), .sync(vs)
    );

    assign ce_pix      = ce_pix_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a reduced 12x8 raster so that 256+
// frames fit in a short run; expectations are queued, a monitor checks each ce_pix.
module tb_video_timing_gen;

    localparam int CE_DIV = 2;
    localparam int CW     = 5;
    localparam int H      = 12;
    localparam int HBE    = 1;
    localparam int HBS    = 9;
    localparam int HSS    = 9;
    localparam int HSE    = 11;
    localparam int V      = 8;
    localparam int VBE    = 1;
    localparam int VBS    = 6;
    localparam int VSS    = 2;
    localparam int VSE    = 4;
    localparam int HV     = H * V;

    logic          clk_sys;
    logic          reset;
    logic [3:0]    h_adj;
    logic [2:0]    v_adj;
    logic          ce_pix;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          hb, vb, hs, vs;
    logic          line_start, frame_start;
    logic [7:0]    frame_cnt;

    typedef struct {
        int k;
        int cyc;
        int h;
        int v;
        bit hb;
        bit vb;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    video_timing_gen #(
        .CE_DIV(CE_DIV), .CW(CW),
        .H_TOTAL(H), .H_BLANK_END(HBE), .H_BLANK_START(HBS),
        .H_SYNC_START(HSS), .H_SYNC_END(HSE),
        .V_TOTAL(V), .V_BLANK_END(VBE), .V_BLANK_START(VBS),
        .V_SYNC_START(VSS), .V_SYNC_END(VSE)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .h_adj(h_adj), .v_adj(v_adj),
        .ce_pix(ce_pix), .hcount(hcount), .vcount(vcount),
        .hb(hb), .vb(vb), .hs(hs), .vs(vs),
        .line_start(line_start), .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Cycles since the edge that last sampled reset high
    always @(posedge clk_sys) begin
        if (reset) cyc = 0;
        else cyc = cyc + 1;
    end

    function automatic int pmod(input int a, input int m);
        return ((a % m) + m) % m;
    endfunction

    // Output at the k-th ce_pix after reset; a sync output is low when the
    // last sync-start event has happened and lies less than one width back
    function automatic exp_t model(input int k, input int hadj, input int vadj);
        exp_t e;
        int   l, p, d, s0;
        l      = k / H;
        e.k    = k;
        e.cyc  = k * CE_DIV;
        e.h    = k % H;
        e.v    = l % V;
        e.hb   = !(e.h > HBE && e.h <= HBS);
        e.vb   = !(e.v > VBE && e.v <= VBS);
        s0     = pmod(HSS + hadj, H);
        p      = pmod(k - 1, H);
        d      = pmod(p - s0, H);
        e.hs   = !(d < (HSE - HSS) && (k - 1 - d) >= 0);
        if (l == 0) begin
            e.vs = 1'b1;
        end else begin
            s0   = pmod(VSS + vadj, V);
            p    = pmod(l - 1, V);
            d    = pmod(p - s0, V);
            e.vs = !(d < (VSE - VSS) && (l - 1 - d) >= 0);
        end
        e.ls   = (e.h == 0);
        e.fs   = (e.h == 0 && e.v == 0);
        e.fc   = (k / HV) % 256;
        return e;
    endfunction

    // Frame 0 runs on the adjust latched at reset, later frames on hadj_rest
    task automatic applyStimulus(input int first_k, input int last_k,
                                 input int hadj0, input int hadj_rest, input int vadj);
        for (int k = first_k; k <= last_k; k++) begin
            sb.push_back(model(k, ((k - 1) / HV == 0) ? hadj0 : hadj_rest, vadj));
        end
    endtask

    task automatic checkOutput(input string name);
        n_checks++;
        if (ce_pix !== 1'b0 || hcount !== '0 || vcount !== '0 || hb !== 1'b1 ||
            vb !== 1'b1 || hs !== 1'b1 || vs !== 1'b1 || line_start !== 1'b0 ||
            frame_start !== 1'b0 || frame_cnt !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL %s: got ce=%0b h=%0d v=%0d hb=%0b vb=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d, expected ce=0 h=0 v=0 hb=1 vb=1 hs=1 vs=1 ls=0 fs=0 fc=0",
                     name, ce_pix, hcount, vcount, hb, vb, hs, vs, line_start, frame_start, frame_cnt);
        end
    endtask

    task automatic resetDut(input string name, input int hadj, input int vadj);
        @(negedge clk_sys);
        h_adj = 4'(hadj);
        v_adj = 3'(vadj);
        reset = 1'b1;
        @(negedge clk_sys);
        checkOutput(name);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        int t;
        budget = sb.size() * CE_DIV + 64;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            @(posedge clk_sys);
            t++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL %s_timeout: %0d ce_pix outstanding after %0d cycles, expected 0",
                     name, sb.size(), budget);
            sb.delete();
        end
    endtask

    always @(negedge clk_sys) begin
        if (!reset && ce_pix === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL unexpected_ce: got ce_pix=1 at cycle %0d h=%0d v=%0d, expected no ce_pix",
                         cyc, hcount, vcount);
            end else begin
                mon_e = sb.pop_front();
                if (cyc != mon_e.cyc || int'(hcount) != mon_e.h || int'(vcount) != mon_e.v ||
                    hb !== mon_e.hb || vb !== mon_e.vb || hs !== mon_e.hs || vs !== mon_e.vs ||
                    line_start !== mon_e.ls || frame_start !== mon_e.fs ||
                    int'(frame_cnt) != mon_e.fc) begin
                    n_fail++;
                    $display("[TB] FAIL ce_%0d: got cyc=%0d h=%0d v=%0d hb=%0b vb=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d, expected cyc=%0d h=%0d v=%0d hb=%0b vb=%0b hs=%0b vs=%0b ls=%0b fs=%0b fc=%0d",
                             mon_e.k, cyc, hcount, vcount, hb, vb, hs, vs, line_start, frame_start, frame_cnt,
                             mon_e.cyc, mon_e.h, mon_e.v, mon_e.hb, mon_e.vb, mon_e.hs, mon_e.vs,
                             mon_e.ls, mon_e.fs, mon_e.fc);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        h_adj = 4'd0;
        v_adj = 3'd0;
        repeat (3) @(posedge clk_sys);

        // Nominal raster; h_adj goes to -8 mid frame 0 and must only act from frame 1
        resetDut("reset_nominal", 0, 0);
        applyStimulus(1, 2 * HV, 0, -8, 0);
        repeat (40 * CE_DIV) @(negedge clk_sys);
        h_adj = 4'b1000;
        drain("adjust_mid_frame");

        // H window wraps past the line end, V window wraps below zero
        resetDut("reset_wrap", 2, -4);
        applyStimulus(1, HV + 3 * H + 5, 2, 2, -4);
        drain("wrap_windows");

        // One-cycle reset at h=5 v=3 of frame 1, then timing restarts from scratch
        resetDut("reset_mid_line", 2, -4);
        applyStimulus(1, HV, 2, 2, -4);
        drain("after_mid_reset");

        // Long run through the frame counter wrap
        resetDut("reset_long", 0, 0);
        applyStimulus(1, 256 * HV + HV / 2, 0, 0, 0);
        drain("frame_cnt_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
